pe_window_gen: RTL and testbench

- Upstream feeder for the 3x3x2 convolution PE.
- Accepts a raster-order stream of 2-channel pixels and buffers the two previous image rows per channel.
- Emits one packed 144-bit 3x3x2 window per valid (unpadded) output position, with valid/ready handshakes on both sides.
- The output bus connects directly to the PE image input.

---
 rtl/pe_window_gen.sv | 172 +++++++++++++++++
 tb/tb_pe_window_gen.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_window_gen.sv
// ---------------------------------------------------------------------------
// pe_window_gen
//   Upstream feeder for the 3x3x2 convolution PE. Takes a raster-order stream
//   of 2-channel pixels, keeps the two previous image rows in line buffers
//   and emits one packed 3x3x2 window for every unpadded output position.
//
// Ports
//   i_clk     clock, all state changes on the rising edge
//   i_rst     synchronous active-high reset
//   i_valid   input pixel valid
//   o_ready   block can accept a pixel this cycle (combinational)
//   i_pixel   {ch0, ch1}, ch0 in the MSBs
//   o_valid   window valid (registered)
//   i_ready   downstream accepts the window
//   o_window  packed window, MSB first: ch0 r0c0, r0c1 ... r2c2, then ch1
//   o_last    marks the final window of the frame (registered)
// ---------------------------------------------------------------------------
module pe_window_gen #(
  parameter int BIT_W = 8,
  parameter int IMG_W = 6,
  parameter int IMG_H = 6
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [2*BIT_W-1:0]  i_pixel,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [18*BIT_W-1:0] o_window,
  output logic                o_last
);

  localparam int PW = 2 * BIT_W;
  localparam int WW = 18 * BIT_W;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  // Raster position of the next pixel to be accepted.
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Line buffers hold both channels side by side; entry IMG_W-1 is the oldest.
  logic [PW-1:0] lb0_q [IMG_W];
  logic [PW-1:0] lb1_q [IMG_W];
  logic [PW-1:0] lb0_out_s;
  logic [PW-1:0] lb1_out_s;

  // Window registers indexed [row][col]; row 0 is the top (oldest) row.
  logic [PW-1:0] win_q [3][3];
  logic [PW-1:0] win_d [3][3];
  logic [WW-1:0] win_pack_s;

  // Output stage.
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic [WW-1:0] window_q, window_d;

  logic accept_s;
  logic emit_s;
  logic col_end_s;
  logic row_end_s;

  // Single output stage with no skid: accept only when the output slot is
  // empty or is being drained this cycle.
  assign o_ready   = ~i_rst & (~valid_q | i_ready);
  assign accept_s  = i_valid & o_ready;
  assign col_end_s = (col_q == CW'(IMG_W - 1));
  assign row_end_s = (row_q == RW'(IMG_H - 1));
  // A window exists only once two full rows and two columns precede it.
  assign emit_s    = accept_s & (row_q >= RW'(2)) & (col_q >= CW'(2));

  // The oldest line-buffer entries are the pixels one and two rows above.
  assign lb0_out_s = lb0_q[IMG_W-1];
  assign lb1_out_s = lb1_q[IMG_W-1];

  assign o_valid  = valid_q;
  assign o_window = window_q;
  assign o_last   = last_q;

  // Next raster position; wraps at end of row and end of frame.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept_s) begin
      if (col_end_s) begin
        col_d = '0;
        if (row_end_s) begin
          row_d = '0;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // Next window: shift columns left, new right column from the line buffers
  // and the incoming pixel, then pack channel 0 ahead of channel 1.
  always_comb begin
    win_pack_s = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 2; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
    end
    win_d[0][2] = lb1_out_s;
    win_d[1][2] = lb0_out_s;
    win_d[2][2] = i_pixel;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_pack_s[WW-1-(r*3+c)*BIT_W -: BIT_W]     = win_d[r][c][PW-1 -: BIT_W];
        win_pack_s[WW/2-1-(r*3+c)*BIT_W -: BIT_W]  = win_d[r][c][BIT_W-1:0];
      end
    end
  end

  // Output stage next state: load on emit, clear once drained, else hold.
  always_comb begin
    valid_d  = valid_q;
    last_d   = last_q;
    window_d = window_q;
    if (emit_s) begin
      valid_d  = 1'b1;
      last_d   = col_end_s & row_end_s;
      window_d = win_pack_s;
    end else if (i_ready) begin
      valid_d  = 1'b0;
    end else begin
      valid_d  = valid_q;
    end
  end

  // Control state and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col_q    <= '0;
      row_q    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      window_q <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      window_q <= window_d;
    end
  end

  // Datapath storage; contents are always refilled before being exposed.
  always_ff @(posedge i_clk) begin
    if (accept_s) begin
      lb0_q[0] <= i_pixel;
      lb1_q[0] <= lb0_out_s;
      for (int i = 1; i < IMG_W; i++) begin
        lb0_q[i] <= lb0_q[i-1];
        lb1_q[i] <= lb1_q[i-1];
      end
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= win_d[r][c];
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_window_gen.sv
// ---------------------------------------------------------------------------
// tb_pe_window_gen
//   Directed self-checking bench for pe_window_gen (6x6 image, 8-bit pixels).
//   Expected windows are computed from pixel coordinates: pixel p of a frame
//   carries ch0 = b0 + p and ch1 = b1 + p.
// ---------------------------------------------------------------------------
module tb_pe_window_gen;

  logic         clk;
  logic         i_rst;
  logic         i_valid;
  logic         o_ready;
  logic [15:0]  i_pixel;
  logic         o_valid;
  logic         i_ready;
  logic [143:0] o_window;
  logic         o_last;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [15:0]  px_q[$];
  logic [143:0] got_w[$];
  logic         got_l[$];

  pe_window_gen #(.BIT_W(8), .IMG_W(6), .IMG_H(6)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_pixel (i_pixel),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_window(o_window),
    .o_last  (o_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Window k (raster order over valid positions) of a frame with bases b0/b1.
  function automatic logic [143:0] exp_win(input int b0, input int b1, input int k);
    logic [143:0] w;
    int r, c, p;
    w = '0;
    r = k / 4 + 2;
    c = k % 4 + 2;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        p = (r - 2 + i) * 6 + (c - 2 + j);
        w[143-(i*3+j)*8 -: 8] = 8'(b0 + p);
        w[71-(i*3+j)*8 -: 8]  = 8'(b1 + p);
      end
    end
    return w;
  endfunction

  task automatic load_frame(input int b0, input int b1);
    for (int p = 0; p < 36; p++) px_q.push_back({8'(b0 + p), 8'(b1 + p)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
  endtask

  // One cycle: drive inputs at the falling edge and sample outputs 1 time unit later.
  task automatic cycle(input logic v, input logic [15:0] px, input logic rdy,
                       output logic ordy, output logic ov,
                       output logic [143:0] w, output logic ol);
    @(negedge clk);
    i_valid = v; i_pixel = px; i_ready = rdy;
    #1;
    ordy = o_ready; ov = o_valid; w = o_window; ol = o_last;
  endtask

  // Streams px_q and records every window handed downstream.
  task automatic collect(input bit bubbles, input bit rand_rdy);
    int sent  = 0;
    int guard = 0;
    logic ordy, ov, ol, v, r;
    logic [143:0] w;
    got_w.delete(); got_l.delete();
    while (sent < px_q.size() && guard < 5000) begin
      v = bubbles ? 1'($urandom_range(1, 0)) : 1'b1;
      r = rand_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
      if (v) cycle(1'b1, px_q[sent], r, ordy, ov, w, ol);
      else   cycle(1'b0, 16'($urandom), r, ordy, ov, w, ol);
      if (ov && r) begin got_w.push_back(w); got_l.push_back(ol); end
      if (v && ordy) sent++;
      guard++;
    end
    repeat (4) begin
      cycle(1'b0, 16'($urandom), 1'b1, ordy, ov, w, ol);
      if (ov) begin got_w.push_back(w); got_l.push_back(ol); end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    i_rst = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
    #1;
    total_cnt++;
    if (o_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", o_ready); else pass_cnt++;
    @(negedge clk);
    i_rst = 1'b0; i_valid = 1'b0;
    #1;
    total_cnt++;
    if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", o_valid); else pass_cnt++;
    total_cnt++;
    if (o_last !== 1'b0) $display("FAIL reset_last: got %b expected 0", o_last); else pass_cnt++;
    total_cnt++;
    if (o_window !== 144'h0) $display("FAIL reset_window: got %h expected 0", o_window); else pass_cnt++;
    total_cnt++;
    if (o_ready !== 1'b1) $display("FAIL reset_ready_after: got %b expected 1", o_ready); else pass_cnt++;
  endtask

  // Full frame every cycle: checks cycle-exact valid pattern incl. row gaps.
  task automatic test_basic_frame();
    logic ordy, ov, ol, exp_v;
    logic [143:0] w;
    int k = 0;
    do_reset();
    px_q.delete(); load_frame(0, 64);
    for (int t = 0; t <= 36; t++) begin
      if (t < 36) cycle(1'b1, px_q[t], 1'b1, ordy, ov, w, ol);
      else        cycle(1'b0, 16'h0, 1'b1, ordy, ov, w, ol);
      exp_v = (t >= 1) && ((t - 1) / 6 >= 2) && ((t - 1) % 6 >= 2);
      total_cnt++;
      if (ov !== exp_v) $display("FAIL basic_valid t=%0d: got %b expected %b", t, ov, exp_v); else pass_cnt++;
      total_cnt++;
      if (ordy !== 1'b1) $display("FAIL basic_ready t=%0d: got %b expected 1", t, ordy); else pass_cnt++;
      if (exp_v && ov) begin
        total_cnt++;
        if (w !== exp_win(0, 64, k)) $display("FAIL basic_win[%0d]: got %h expected %h", k, w, exp_win(0, 64, k)); else pass_cnt++;
        total_cnt++;
        if (ol !== (k == 15)) $display("FAIL basic_last[%0d]: got %b expected %b", k, ol, (k == 15)); else pass_cnt++;
        k++;
      end
    end
    total_cnt++;
    if (k != 16) $display("FAIL basic_count: got %0d expected 16", k); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic ordy, ov, ol;
    logic [143:0] w;
    int sent = 0, stall = 0, guard = 0;
    do_reset();
    px_q.delete(); load_frame(0, 64);
    got_w.delete(); got_l.delete();
    while (sent < 36 && guard < 500) begin
      if (sent == 16 && stall < 5) begin
        cycle(1'b1, px_q[sent], 1'b0, ordy, ov, w, ol);
        total_cnt++;
        if (ordy !== 1'b0) $display("FAIL bp_ready s=%0d: got %b expected 0", stall, ordy); else pass_cnt++;
        total_cnt++;
        if (ov !== 1'b1) $display("FAIL bp_valid s=%0d: got %b expected 1", stall, ov); else pass_cnt++;
        total_cnt++;
        if (w !== exp_win(0, 64, 1)) $display("FAIL bp_hold s=%0d: got %h expected %h", stall, w, exp_win(0, 64, 1)); else pass_cnt++;
        stall++;
      end else begin
        cycle(1'b1, px_q[sent], 1'b1, ordy, ov, w, ol);
        if (ov) begin got_w.push_back(w); got_l.push_back(ol); end
      end
      if (ordy) sent++;
      guard++;
    end
    repeat (4) begin
      cycle(1'b0, 16'h0, 1'b1, ordy, ov, w, ol);
      if (ov) begin got_w.push_back(w); got_l.push_back(ol); end
    end
    total_cnt++;
    if (got_w.size() != 16) $display("FAIL bp_count: got %0d expected 16", got_w.size()); else pass_cnt++;
    for (int k = 0; k < got_w.size() && k < 16; k++) begin
      total_cnt++;
      if (got_w[k] !== exp_win(0, 64, k)) $display("FAIL bp_win[%0d]: got %h expected %h", k, got_w[k], exp_win(0, 64, k)); else pass_cnt++;
    end
  endtask

  task automatic test_bubbles();
    do_reset();
    px_q.delete(); load_frame(10, 90);
    collect(1'b1, 1'b1);
    total_cnt++;
    if (got_w.size() != 16) $display("FAIL bub_count: got %0d expected 16", got_w.size()); else pass_cnt++;
    for (int k = 0; k < got_w.size() && k < 16; k++) begin
      total_cnt++;
      if (got_w[k] !== exp_win(10, 90, k)) $display("FAIL bub_win[%0d]: got %h expected %h", k, got_w[k], exp_win(10, 90, k)); else pass_cnt++;
      total_cnt++;
      if (got_l[k] !== (k == 15)) $display("FAIL bub_last[%0d]: got %b expected %b", k, got_l[k], (k == 15)); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [143:0] e;
    do_reset();
    px_q.delete(); load_frame(0, 64); load_frame(100, 164);
    collect(1'b0, 1'b0);
    total_cnt++;
    if (got_w.size() != 32) $display("FAIL b2b_count: got %0d expected 32", got_w.size()); else pass_cnt++;
    for (int k = 0; k < got_w.size() && k < 32; k++) begin
      e = (k < 16) ? exp_win(0, 64, k) : exp_win(100, 164, k - 16);
      total_cnt++;
      if (got_w[k] !== e) $display("FAIL b2b_win[%0d]: got %h expected %h", k, got_w[k], e); else pass_cnt++;
      total_cnt++;
      if (got_l[k] !== (k == 15 || k == 31)) $display("FAIL b2b_last[%0d]: got %b expected %b", k, got_l[k], (k == 15 || k == 31)); else pass_cnt++;
    end
  endtask

  task automatic test_mid_reset();
    logic ordy, ov, ol;
    logic [143:0] w;
    do_reset();
    px_q.delete(); load_frame(0, 64);
    for (int p = 0; p <= 20; p++) cycle(1'b1, px_q[p], 1'b1, ordy, ov, w, ol);
    @(negedge clk);
    #1;
    total_cnt++;
    if (o_valid !== 1'b1 || o_window !== exp_win(0, 64, 4))
      $display("FAIL mrst_pre: got %b/%h expected 1/%h", o_valid, o_window, exp_win(0, 64, 4));
    else pass_cnt++;
    i_rst = 1'b1; i_valid = 1'b1; i_ready = 1'b1; i_pixel = 16'hABCD;
    #1;
    total_cnt++;
    if (o_ready !== 1'b0) $display("FAIL mrst_ready: got %b expected 0", o_ready); else pass_cnt++;
    @(negedge clk);
    i_rst = 1'b0; i_valid = 1'b0;
    #1;
    total_cnt++;
    if (o_valid !== 1'b0) $display("FAIL mrst_valid: got %b expected 0", o_valid); else pass_cnt++;
    total_cnt++;
    if (o_last !== 1'b0) $display("FAIL mrst_last: got %b expected 0", o_last); else pass_cnt++;
    total_cnt++;
    if (o_window !== 144'h0) $display("FAIL mrst_window: got %h expected 0", o_window); else pass_cnt++;
    px_q.delete(); load_frame(128, 192);
    collect(1'b0, 1'b0);
    total_cnt++;
    if (got_w.size() != 16) $display("FAIL mrst_count: got %0d expected 16", got_w.size()); else pass_cnt++;
    for (int k = 0; k < got_w.size() && k < 16; k++) begin
      total_cnt++;
      if (got_w[k] !== exp_win(128, 192, k)) $display("FAIL mrst_win[%0d]: got %h expected %h", k, got_w[k], exp_win(128, 192, k)); else pass_cnt++;
      total_cnt++;
      if (got_l[k] !== (k == 15)) $display("FAIL mrst_last_flag[%0d]: got %b expected %b", k, got_l[k], (k == 15)); else pass_cnt++;
    end
  endtask

  initial begin
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_pixel = 16'h0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_bubbles();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
